// File: rtl/rvvi_depacketizer_pkg.sv
// rtl/rvvi_depacketizer_pkg.sv - shared RVVI trace framing constants and width helpers
package rvvi_depacketizer_pkg;

  // Core configuration slice; only XLEN matters for the trace vector width.
  typedef struct packed {
    logic [31:0] XLEN;
  } cvw_t;

  localparam cvw_t CVW_RV64 = '{XLEN: 32'd64};

  // Framing shared with the packetizer so both ends agree on layout.
  localparam int          RVVI_HDR_WORDS  = 4;
  localparam logic [15:0] RVVI_ETHER_TYPE = 16'h005C;

  // Width of one RVVI trace vector for a given core config and CSR slot count.
  function automatic int rvvi_width(input cvw_t p, input int max_csrs);
    return 72 + 5 * int'(p.XLEN) + max_csrs * (int'(p.XLEN) + 16);
  endfunction

  // Number of 32-bit payload words needed to carry a vector of the given width.
  function automatic int rvvi_pay_words(input int width);
    return (width + 31) / 32;
  endfunction

endpackage

// File: rtl/rvvi_depacketizer.sv
// rtl/rvvi_depacketizer.sv - reassembles RVVI trace vectors from Ethernet RX frames
module rvvi_depacketizer
  import rvvi_depacketizer_pkg::*;
#(
  parameter cvw_t        P          = CVW_RV64,
  parameter int          MAX_CSRS   = 5,
  parameter logic [15:0] ETHER_TYPE = RVVI_ETHER_TYPE,
  localparam int         RVVI_W     = rvvi_width(P, MAX_CSRS)
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [31:0]       RxTdata,
  input  logic [3:0]        RxTkeep,
  input  logic              RxTvalid,
  output logic              RxTready,
  input  logic              RxTlast,
  input  logic              RxTuser,
  output logic [RVVI_W-1:0] Rvvi,
  output logic              RvviValid,
  input  logic              RvviReady,
  output logic [31:0]       FrameCount,
  output logic [15:0]       DropCount
);

  localparam int PAY_WORDS   = rvvi_pay_words(RVVI_W);
  localparam int FRAME_WORDS = RVVI_HDR_WORDS + PAY_WORDS;
  localparam int CW          = $clog2(FRAME_WORDS + 1);
  localparam int ASM_W       = PAY_WORDS * 32;

  localparam logic [CW-1:0] HDR_LAST = CW'(RVVI_HDR_WORDS - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] HDR_CNT  = CW'(RVVI_HDR_WORDS);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [RVVI_W-1:0] rvvi_q, rvvi_d;
  logic              valid_q, valid_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] slot;
  logic          last_slot;
  logic          stall;
  logic          accept;
  logic          commit;
  logic          drop;
  logic          unused_bits;

  assign slot      = cnt_q - HDR_CNT;
  assign last_slot = (state_q == ST_PAYLOAD) && (cnt_q == PAY_LAST);
  // Hold the final payload word off while the output buffer is still occupied.
  assign stall     = last_slot && valid_q && !RvviReady;
  assign RxTready  = s_axi_aresetn && !stall;
  assign accept    = RxTvalid && RxTready;

  assign unused_bits = ^{RxTkeep, asm_d[ASM_W-1:RVVI_W]};

  // Frame parser: header check, payload assembly, commit/drop decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    rvvi_d      = rvvi_q;
    valid_d     = valid_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    commit      = 1'b0;
    drop        = 1'b0;

    if (valid_q && RvviReady) valid_d = 1'b0;

    if (accept) begin
      cnt_d = RxTlast ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
      case (state_q)
        ST_HEADER: begin
          if (RxTlast) begin
            drop = 1'b1;
          end else if (cnt_q == HDR_LAST) begin
            if (RxTdata[15:0] == ETHER_TYPE) begin
              state_d = ST_PAYLOAD;
            end else begin
              state_d = ST_DISCARD;
              drop    = 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          asm_d[int'(slot) * 32 +: 32] = RxTdata;
          if (cnt_q == PAY_LAST) begin
            state_d = RxTlast ? ST_HEADER : ST_DISCARD;
            if (RxTlast && !RxTuser) commit = 1'b1;
            else                     drop   = 1'b1;
          end else if (RxTlast) begin
            state_d = ST_HEADER;
            drop    = 1'b1;
          end
        end
        ST_DISCARD: begin
          if (RxTlast) state_d = ST_HEADER;
        end
        default: state_d = ST_HEADER;
      endcase
    end

    // Commit may coincide with the consumer taking the previous vector.
    if (commit) begin
      rvvi_d      = asm_d[RVVI_W-1:0];
      valid_d     = 1'b1;
      frame_cnt_d = frame_cnt_q + 32'd1;
    end

    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // State and output registers; reset may land mid-frame.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_HEADER;
      cnt_q       <= '0;
      asm_q       <= '0;
      rvvi_q      <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      rvvi_q      <= rvvi_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign Rvvi       = rvvi_q;
  assign RvviValid  = valid_q;
  assign FrameCount = frame_cnt_q;
  assign DropCount  = drop_cnt_q;

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// tb/tb_rvvi_depacketizer.sv - self-checking bench for rvvi_depacketizer
module tb_rvvi_depacketizer;

  localparam int W   = 792;
  localparam int PAY = 25;
  localparam int NW  = 29;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   RxTdata;
  logic [3:0]    RxTkeep;
  logic          RxTvalid;
  logic          RxTready;
  logic          RxTlast;
  logic          RxTuser;
  logic [W-1:0]  Rvvi;
  logic          RvviValid;
  logic          RvviReady;
  logic [31:0]   FrameCount;
  logic [15:0]   DropCount;

  rvvi_depacketizer dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .RxTdata      (RxTdata),
    .RxTkeep      (RxTkeep),
    .RxTvalid     (RxTvalid),
    .RxTready     (RxTready),
    .RxTlast      (RxTlast),
    .RxTuser      (RxTuser),
    .Rvvi         (Rvvi),
    .RvviValid    (RvviValid),
    .RvviReady    (RvviReady),
    .FrameCount   (FrameCount),
    .DropCount    (DropCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected packets in delivery order and expected counters.
  logic [W-1:0] exp_q[$];
  int           exp_frames = 0;
  int           exp_drops  = 0;
  int           deliveries = 0;
  logic [W-1:0] last_rvvi  = '0;

  bit ready_rand  = 1'b0;
  bit ready_fixed = 1'b1;
  bit bg_done;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  // Consumer ready: either a fixed level or random backpressure.
  always @(posedge clk) begin
    #1;
    RvviReady = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  // Output monitor: in-order scoreboard and stability while stalled.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_rvvi = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", W'(RvviValid), W'(1));
        chk("hold_data", Rvvi, prev_rvvi);
      end
      if (RvviValid && RvviReady) begin
        chk("pkt_expected", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) chk("pkt_data", Rvvi, exp_q.pop_front());
        last_rvvi = Rvvi;
        deliveries++;
      end
      prev_hold = RvviValid && !RvviReady;
      prev_rvvi = Rvvi;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input bit user, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        RxTvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    RxTdata  = d;
    RxTlast  = last;
    RxTuser  = user;
    RxTkeep  = 4'hF;
    RxTvalid = 1'b1;
    budget   = 2000;
    forever begin
      @(negedge clk);
      if (RxTready) begin
        @(posedge clk);
        #1;
        break;
      end
      budget--;
      if (budget == 0) begin
        chk("rx_timeout", W'(RxTready), W'(1));
        break;
      end
    end
    RxTvalid = 1'b0;
    RxTlast  = 1'b0;
    RxTuser  = 1'b0;
  endtask

  // A frame is good only when it has exactly header+payload words, the right
  // EtherType and no MAC error; every other frame counts as one drop.
  task automatic send_frame(input int n, input logic [15:0] et, input bit user,
                            input logic [31:0] base, input bit rnd, input bit gaps);
    logic [PAY*32-1:0] v;
    logic [31:0]       w;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 3)       w = $urandom;
      else if (i == 3) w = {16'hA5A5, et};
      else             w = rnd ? $urandom : base + 32'(i - 4);
      if (i >= 4 && i < 4 + PAY) v[(i - 4) * 32 +: 32] = w;
      send_word(w, i == n - 1, (i == n - 1) ? user : 1'b0, gaps);
    end
    if (n == NW && et == 16'h005C && !user) begin
      exp_q.push_back(v[W-1:0]);
      exp_frames++;
    end else if (exp_drops < 65535) begin
      exp_drops++;
    end
  endtask

  task automatic drain();
    int budget = 5000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    chk("drain", W'(exp_q.size()), W'(0));
    idle(3);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frames"}, W'(FrameCount), W'(exp_frames));
    chk({tag, "_drops"}, W'(DropCount), W'(exp_drops));
  endtask

  initial begin
    int n;
    bit user;
    logic [15:0] et;

    rst_n    = 1'b0;
    RxTdata  = '0;
    RxTkeep  = '0;
    RxTvalid = 1'b0;
    RxTlast  = 1'b0;
    RxTuser  = 1'b0;
    idle(3);
    chk("rst_rxtready", W'(RxTready), W'(0));
    chk("rst_valid", W'(RvviValid), W'(0));
    chk("rst_rvvi", Rvvi, '0);
    check_counts("rst");
    rst_n = 1'b1;
    idle(2);

    // Single good frame with counting payload.
    send_frame(NW, 16'h005C, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
    idle(5);
    chk("good_deliveries", W'(deliveries), W'(1));
    chk("good_lo", W'(last_rvvi[31:0]), W'(32'h1000_0000));
    chk("good_hi", W'(last_rvvi[791:768]), W'(24'h000018));
    check_counts("good");

    // Wrong EtherType followed by a good frame.
    send_frame(NW, 16'h0800, 1'b0, 32'h2000_0000, 1'b0, 1'b0);
    send_frame(NW, 16'h005C, 1'b0, 32'h3000_0000, 1'b0, 1'b0);
    drain();
    chk("et_lo", W'(last_rvvi[31:0]), W'(32'h3000_0000));
    check_counts("ethertype");

    // Runt in payload, over-long frame, MAC error on last word.
    send_frame(15, 16'h005C, 1'b0, 32'h6000_0000, 1'b0, 1'b0);
    send_frame(30, 16'h005C, 1'b0, 32'h6100_0000, 1'b0, 1'b0);
    send_frame(NW, 16'h005C, 1'b1, 32'h6200_0000, 1'b0, 1'b0);
    idle(5);
    chk("bad_deliveries", W'(deliveries), W'(2));
    check_counts("bad");

    // Backpressure: second frame stalls on its last word until consumed.
    ready_fixed = 1'b0;
    idle(2);
    send_frame(NW, 16'h005C, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    bg_done = 1'b0;
    fork
      begin
        send_frame(NW, 16'h005C, 1'b0, 32'h5000_0000, 1'b0, 1'b0);
        bg_done = 1'b1;
      end
    join_none
    idle(40);
    chk("stall_rxtready", W'(RxTready), W'(0));
    chk("stall_valid", W'(RvviValid), W'(1));
    chk("stall_lo", W'(Rvvi[31:0]), W'(32'h4000_0000));
    ready_fixed = 1'b1;
    for (int i = 0; i < 3000 && !bg_done; i++) idle(1);
    chk("stall_done", W'(bg_done), W'(1));
    drain();
    chk("stall_last", W'(last_rvvi[31:0]), W'(32'h5000_0000));
    check_counts("stall");

    // Asynchronous reset in the middle of a payload.
    for (int i = 0; i < 17; i++)
      send_word((i == 3) ? 32'hA5A5_005C : 32'h7000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rxtready", W'(RxTready), W'(0));
    chk("arst_valid", W'(RvviValid), W'(0));
    chk("arst_rvvi", Rvvi, '0);
    chk("arst_frames", W'(FrameCount), W'(0));
    chk("arst_drops", W'(DropCount), W'(0));
    exp_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_frame(NW, 16'h005C, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    drain();
    chk("arst_next_lo", W'(last_rvvi[31:0]), W'(32'h8000_0000));
    check_counts("arst");

    // Random traffic with gaps on both sides.
    ready_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n    = ($urandom_range(0, 9) < 6) ? NW : $urandom_range(1, 31);
      et   = ($urandom_range(0, 9) < 8) ? 16'h005C : 16'($urandom);
      user = ($urandom_range(0, 9) == 0);
      send_frame(n, et, user, 32'h0, 1'b1, 1'b1);
    end
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    idle(2);
    drain();
    check_counts("random");

    // Drop counter saturation with single-word runts.
    for (int i = 0; i < 66000; i++) begin
      send_word($urandom, 1'b1, 1'b0, 1'b0);
      if (exp_drops < 65535) exp_drops++;
    end
    idle(3);
    chk("sat_drops", W'(DropCount), W'(16'hFFFF));
    check_counts("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
